// File: rtl/seq_shift_unit.sv
// ---------------------------------------------------------------------------
// seq_shift_unit
//
// Multi-cycle shifter for the execute stage. A shift is split into
// SHAMT_WIDTH barrel stages, one per clock, with the largest distance first
// (16, 8, 4, 2, 1 for the default widths). Each clock, one stage either
// shifts the working register by its distance or leaves it unchanged. It
// shifts only when the matching bit of the latched shift amount is set.
//
// The datapath uses the same handshake as the multdiv unit. It gives a
// one-cycle start pulse with the operands. The unit then drives a one-cycle
// ready strobe when the registered result is new.
//
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous, active-low reset (0 = reset asserted)
//   ctrl_start     one-cycle request; operands are sampled on this edge
//   data_operandA  value to shift
//   ctrl_shiftamt  unsigned shift amount
//   ctrl_shiftop   00 SLL, 01 SRA, 10 SRL, 11 pass-through
//   data_result    shifted value, held until the next op completes
//   data_resultRDY high for exactly one cycle when data_result is new
//   data_busy      high while a shift is in progress
// ---------------------------------------------------------------------------
module seq_shift_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ctrl_start,
  input  logic [DATA_WIDTH-1:0]  data_operandA,
  input  logic [SHAMT_WIDTH-1:0] ctrl_shiftamt,
  input  logic [1:0]             ctrl_shiftop,
  output logic [DATA_WIDTH-1:0]  data_result,
  output logic                   data_resultRDY,
  output logic                   data_busy
);

  // Stage counter width: enough bits to count 0..SHAMT_WIDTH-1.
  localparam int CW = (SHAMT_WIDTH > 1) ? $clog2(SHAMT_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STAGE = CW'(SHAMT_WIDTH - 1);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_SRL = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t                 r_state;
  state_t                 w_nextState;

  logic [DATA_WIDTH-1:0]  r_work;
  logic [SHAMT_WIDTH-1:0] r_amt;
  logic [1:0]             r_op;
  logic                   r_sign;
  logic [CW-1:0]          r_count;
  logic [DATA_WIDTH-1:0]  r_result;

  logic                   w_accept;
  logic                   w_step;
  logic                   w_last;
  logic [CW-1:0]          w_bitIdx;
  logic                   w_amtBit;
  logic [SHAMT_WIDTH-1:0] w_dist;
  logic [DATA_WIDTH-1:0]  w_fillMask;
  logic [DATA_WIDTH-1:0]  w_stageOut;

  // Stage k uses amount bit (SHAMT_WIDTH-1-k). Its distance is 2**(that bit
  // index), so the largest distance is applied first.
  assign w_bitIdx   = LAST_STAGE - r_count;
  assign w_amtBit   = r_amt[w_bitIdx];
  assign w_dist     = {{(SHAMT_WIDTH-1){1'b0}}, 1'b1} << w_bitIdx;
  // Ones in the top w_dist positions. For SRA these bits are filled with
  // the operand's original sign bit, which r_sign keeps for all stages.
  assign w_fillMask = ~({DATA_WIDTH{1'b1}} >> w_dist);

  // One barrel stage. It is the same single-stage structure used by the
  // combinational shifter, and it runs once per clock here.
  always_comb begin
    w_stageOut = r_work;
    if (w_amtBit) begin
      case (r_op)
        OP_SLL:  w_stageOut = r_work << w_dist;
        OP_SRL:  w_stageOut = r_work >> w_dist;
        OP_SRA:  w_stageOut = (r_work >> w_dist) | (r_sign ? w_fillMask : '0);
        default: w_stageOut = r_work;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. The unit accepts a start in IDLE and also in DONE, so
  // ops can run back to back. A start during SHIFT is ignored.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (ctrl_start) begin
          w_accept    = 1'b1;
          w_nextState = SHIFT;
        end
      end
      SHIFT: begin
        w_step = 1'b1;
        if (r_count == LAST_STAGE) begin
          w_last      = 1'b1;
          w_nextState = DONE;
        end
      end
      DONE: begin
        if (ctrl_start) begin
          w_accept    = 1'b1;
          w_nextState = SHIFT;
        end else begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath registers. The operands are captured only on the accepting
  // edge. Later input changes do not reach the op in flight. The result
  // register is loaded only on the edge that applies the final stage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_work   <= '0;
      r_amt    <= '0;
      r_op     <= '0;
      r_sign   <= 1'b0;
      r_count  <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_work  <= data_operandA;
        r_amt   <= ctrl_shiftamt;
        r_op    <= ctrl_shiftop;
        r_sign  <= data_operandA[DATA_WIDTH-1];
        r_count <= '0;
      end else if (w_step) begin
        r_work  <= w_stageOut;
        r_count <= r_count + CW'(1);
      end
      if (w_last) begin
        r_result <= w_stageOut;
      end
    end
  end

  assign data_result    = r_result;
  assign data_resultRDY = (r_state == DONE);
  assign data_busy      = (r_state == SHIFT);

endmodule

// File: tb/tb_seq_shift_unit.sv
// ---------------------------------------------------------------------------
// tb_seq_shift_unit
//
// Directed testbench for seq_shift_unit. It runs a fixed list of shift ops.
// Each expected value is computed by hand from the shift definitions and
// checked at fixed cycle offsets from the accepting edge.
// ---------------------------------------------------------------------------
module tb_seq_shift_unit;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRA  = 2'b01;
  localparam logic [1:0] OP_SRL  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  logic        clock;
  logic        reset;
  logic        ctrl_start;
  logic [31:0] data_operandA;
  logic [4:0]  ctrl_shiftamt;
  logic [1:0]  ctrl_shiftop;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        data_busy;

  int checkCount;
  int errorCount;

  seq_shift_unit #(
    .DATA_WIDTH  (32),
    .SHAMT_WIDTH (5)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_start     (ctrl_start),
    .data_operandA  (data_operandA),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .ctrl_shiftop   (ctrl_shiftop),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .data_busy      (data_busy)
  );

  // 10 ns clock period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Move 1 ns past the next rising edge, where the outputs have settled.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Compare one observed value with its expected value and record the result.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drive one start pulse with the given operands and wait through the
  // accepting edge (E0). Afterwards, scramble the operand inputs so that a
  // late-sampling design would produce a wrong result.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                               input logic [4:0] amt);
    ctrl_shiftop  = op;
    data_operandA = a;
    ctrl_shiftamt = amt;
    ctrl_start    = 1'b1;
    tick();
    ctrl_start    = 1'b0;
    data_operandA = ~a;
    ctrl_shiftamt = ~amt;
    ctrl_shiftop  = ~op;
  endtask

  // Run one full op and check the timeline. Busy is high for the cycles
  // after E0..E4. The result and the ready strobe appear after E5, and
  // ready drops after E6 while the result is held.
  task automatic runOp(input string tag, input logic [1:0] op,
                       input logic [31:0] a, input logic [4:0] amt,
                       input logic [31:0] expected);
    applyStimulus(op, a, amt);
    checkOutput({tag, " busyE0"}, 32'(data_busy), 32'd1);
    checkOutput({tag, " rdyE0"}, 32'(data_resultRDY), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      checkOutput({tag, " busyMid"}, 32'(data_busy), 32'd1);
      checkOutput({tag, " rdyMid"}, 32'(data_resultRDY), 32'd0);
    end
    tick();
    checkOutput({tag, " rdyE5"}, 32'(data_resultRDY), 32'd1);
    checkOutput({tag, " busyE5"}, 32'(data_busy), 32'd0);
    checkOutput({tag, " result"}, data_result, expected);
    tick();
    checkOutput({tag, " rdyE6"}, 32'(data_resultRDY), 32'd0);
    checkOutput({tag, " held"}, data_result, expected);
  endtask

  initial begin
    checkCount    = 0;
    errorCount    = 0;
    reset         = 1'b0;
    ctrl_start    = 1'b0;
    data_operandA = '0;
    ctrl_shiftamt = '0;
    ctrl_shiftop  = '0;

    // Reset state.
    tick();
    tick();
    checkOutput("reset result", data_result, 32'h0);
    checkOutput("reset rdy", 32'(data_resultRDY), 32'd0);
    checkOutput("reset busy", 32'(data_busy), 32'd0);
    reset = 1'b1;

    // Main function and boundary amounts.
    runOp("sll8", OP_SLL, 32'h0000_00FF, 5'd8, 32'h0000_FF00);
    runOp("sra31", OP_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    runOp("srl31", OP_SRL, 32'h8000_0000, 5'd31, 32'h0000_0001);
    runOp("sll31", OP_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000);
    runOp("sraPos", OP_SRA, 32'h7000_0000, 5'd4, 32'h0700_0000);
    runOp("srlNeg", OP_SRL, 32'hF000_0000, 5'd4, 32'h0F00_0000);
    runOp("sraMix", OP_SRA, 32'h8765_4321, 5'd13, 32'hFFFC_3B2A);
    runOp("shamt0", OP_SLL, 32'h1234_5678, 5'd0, 32'h1234_5678);
    runOp("pass", OP_PASS, 32'h1234_5678, 5'd5, 32'h1234_5678);

    // A start during SHIFT is ignored.
    applyStimulus(OP_SLL, 32'h0000_0001, 5'd4);
    tick();
    ctrl_start    = 1'b1;
    data_operandA = 32'hFFFF_FFFF;
    tick();
    ctrl_start    = 1'b0;
    checkOutput("ign busyE2", 32'(data_busy), 32'd1);
    tick();
    tick();
    tick();
    checkOutput("ign rdyE5", 32'(data_resultRDY), 32'd1);
    checkOutput("ign result", data_result, 32'h0000_0010);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("ign noRdy", 32'(data_resultRDY), 32'd0);
      checkOutput("ign noBusy", 32'(data_busy), 32'd0);
      checkOutput("ign held", data_result, 32'h0000_0010);
    end

    // An asynchronous reset in the middle of an op aborts it.
    applyStimulus(OP_SRA, 32'hF000_0000, 5'd4);
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    checkOutput("abort result", data_result, 32'h0);
    checkOutput("abort rdy", 32'(data_resultRDY), 32'd0);
    checkOutput("abort busy", 32'(data_busy), 32'd0);
    tick();
    tick();
    checkOutput("abort stillRst", 32'(data_busy), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checkOutput("abort noRdy", 32'(data_resultRDY), 32'd0);
      tick();
    end
    runOp("afterRst", OP_SRA, 32'hF000_0000, 5'd4, 32'hFF00_0000);

    // Back to back. Op2 is started during op1's DONE cycle.
    applyStimulus(OP_SLL, 32'h0000_0003, 5'd1);
    for (int i = 1; i <= 4; i++) tick();
    tick();
    checkOutput("b2b rdy1", 32'(data_resultRDY), 32'd1);
    checkOutput("b2b res1", data_result, 32'h0000_0006);
    ctrl_shiftop  = OP_SRL;
    data_operandA = 32'h0000_0100;
    ctrl_shiftamt = 5'd8;
    ctrl_start    = 1'b1;
    tick();
    ctrl_start    = 1'b0;
    data_operandA = 32'hDEAD_BEEF;
    checkOutput("b2b busy2", 32'(data_busy), 32'd1);
    checkOutput("b2b rdyGap", 32'(data_resultRDY), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      checkOutput("b2b rdyMid", 32'(data_resultRDY), 32'd0);
      checkOutput("b2b hold1", data_result, 32'h0000_0006);
    end
    tick();
    checkOutput("b2b rdy2", 32'(data_resultRDY), 32'd1);
    checkOutput("b2b res2", data_result, 32'h0000_0001);
    tick();
    checkOutput("b2b rdyOff", 32'(data_resultRDY), 32'd0);
    checkOutput("b2b idleBusy", 32'(data_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
